// File: rtl/vga_window_streamer_if.sv
// Avalon-ST video stream bundle: pixel data with packet framing and
// readyLatency-0 backpressure.
interface vga_window_streamer_if #(
  parameter int DATA_W = 30
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              startofpacket;
  logic              endofpacket;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );
endinterface

// File: rtl/vga_window_streamer.sv
// Frame-per-packet Avalon-ST video source: a rectangular window is fed from a
// synchronous line buffer, and the background colour fills the rest of the frame.
module vga_window_streamer #(
  parameter int                     H_RES      = 640,
  parameter int                     V_RES      = 480,
  parameter int                     WIN_X0     = 80,
  parameter int                     WIN_X1     = 480,
  parameter int                     WIN_Y0     = 0,
  parameter int                     WIN_Y1     = 479,
  parameter int                     IN_BITS    = 8,
  parameter int                     OUT_BITS   = 10,
  parameter int                     EXPAND     = 0,
  parameter logic [3*OUT_BITS-1:0]  BG         = '0,
  parameter int                     ROW_LEAD   = 40,
  parameter int                     FRAME_LEAD = 100,
  parameter int                     ADDR_W     = 9
) (
  input  logic                      clock_vga,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [3*IN_BITS-1:0]      data,
  output logic [ADDR_W-1:0]         address,
  output logic                      next_row,
  output logic                      next_screen,
  vga_window_streamer_if.master     avalon_streaming_source
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PW = 3 * OUT_BITS;

  localparam logic [XW-1:0] LAST_X  = XW'(H_RES - 1);
  localparam logic [YW-1:0] LAST_Y  = YW'(V_RES - 1);
  localparam logic [XW-1:0] ROW_X   = XW'(H_RES - ROW_LEAD);
  localparam logic [XW-1:0] FRAME_X = XW'(H_RES - FRAME_LEAD);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [PW-1:0]   pix;
  logic            vld, sop, eop;
  logic            load, drop, last_pix, ready;

  function automatic logic in_window(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (int'(px) >= WIN_X0) && (int'(px) <= WIN_X1) &&
           (int'(py) >= WIN_Y0) && (int'(py) <= WIN_Y1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [XW-1:0] px, input logic [YW-1:0] py);
    if (in_window(px, py)) return ADDR_W'(int'(px) - WIN_X0);
    return '0;
  endfunction

  // MSB-aligned widening; the spare LSBs are zero or a cyclic copy of the MSBs.
  function automatic logic [OUT_BITS-1:0] widen(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      if (i < IN_BITS)
        w[OUT_BITS-1-i] = c[IN_BITS-1-i];
      else if (EXPAND != 0)
        w[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] pixel_of(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                             input logic [3*IN_BITS-1:0] rgb);
    if (in_window(px, py))
      return {widen(rgb[3*IN_BITS-1:2*IN_BITS]),
              widen(rgb[2*IN_BITS-1:IN_BITS]),
              widen(rgb[IN_BITS-1:0])};
    return BG;
  endfunction

  assign ready    = avalon_streaming_source.ready;
  assign last_pix = (x == LAST_X) && (y == LAST_Y);

  always_comb begin
    x_nxt = (x == LAST_X) ? '0 : x + 1'b1;
    y_nxt = y;
    if (x == LAST_X)
      y_nxt = (y == LAST_Y) ? '0 : y + 1'b1;
  end

  // A new frame is only committed at the eop load; DRAIN lets the last beat leave.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = PRIME;
      PRIME:  state_nxt = STREAM;
      STREAM: begin
        if (!vld || ready) begin
          load = 1'b1;
          if (last_pix && !start) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ready) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_vga or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      address     <= '0;
      pix         <= '0;
      vld         <= 1'b0;
      sop         <= 1'b0;
      eop         <= 1'b0;
      next_row    <= 1'b0;
      next_screen <= 1'b0;
    end else begin
      state       <= state_nxt;
      next_row    <= load && (x == ROW_X);
      next_screen <= load && (x == FRAME_X) && (y == LAST_Y);
      if (state == IDLE && start) begin
        x       <= '0;
        y       <= '0;
        address <= addr_of('0, '0);
      end
      // Output register stage: load pixel (x,y), then point the RAM at the next one.
      if (load) begin
        pix     <= pixel_of(x, y, data);
        sop     <= (x == '0) && (y == '0);
        eop     <= last_pix;
        vld     <= 1'b1;
        x       <= x_nxt;
        y       <= y_nxt;
        address <= addr_of(x_nxt, y_nxt);
      end else if (drop) begin
        vld <= 1'b0;
        sop <= 1'b0;
        eop <= 1'b0;
      end
    end
  end

  assign avalon_streaming_source.data          = pix;
  assign avalon_streaming_source.valid         = vld;
  assign avalon_streaming_source.startofpacket = sop;
  assign avalon_streaming_source.endofpacket   = eop;

endmodule

// File: doc/vga_window_streamer.md
# vga_window_streamer

Parametrised Avalon-ST video source for the VGA output path. Generates one frame of H_RES×V_RES pixels per packet, with an arbitrary rectangular active window fed from a synchronous line buffer and a background colour elsewhere. Honours full `ready` backpressure through a one-entry output register. Issues `next_row` and `next_screen` early-warning pulses so upstream logic can refill the line buffer and prepare the next frame.

## Interface
- H_RES, 640: pixels per row.
- V_RES, 480: rows per frame.
- WIN_X0, 80: first active column (inclusive).
- WIN_X1, 480: last active column (inclusive). Requires WIN_X0 ≤ WIN_X1 < H_RES.
- WIN_Y0, 0: first active row (inclusive).
- WIN_Y1, 479: last active row (inclusive). Requires WIN_Y0 ≤ WIN_Y1 < V_RES.
- IN_BITS, 8: bits per colour channel on `data`.
- OUT_BITS, 10: bits per colour channel on the source; OUT_BITS ≥ IN_BITS.
- EXPAND, 0: channel widening mode. 0 = zero-pad LSBs; 1 = replicate MSBs into LSBs.
- BG, 0: 3*OUT_BITS background colour, emitted outside the window.
- ROW_LEAD, 40: columns before row end at which `next_row` fires; 1 ≤ ROW_LEAD ≤ H_RES.
- FRAME_LEAD, 100: pixels before frame end at which `next_screen` fires; 1 ≤ FRAME_LEAD ≤ H_RES.
- ADDR_W, 9: line-buffer address width; 2^ADDR_W ≥ WIN_X1−WIN_X0+1.

Ports:
- clock_vga, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: enable streaming; sampled only at frame boundaries.
- data, in, 3*IN_BITS: line-buffer read data {R,G,B}, valid one cycle after `address`.
- address, out, ADDR_W: line-buffer read address (registered).
- next_row, out, 1: one-cycle early-warning pulse, row end.
- next_screen, out, 1: one-cycle early-warning pulse, frame end.
- avalon_streaming_source_data, out, 3*OUT_BITS: pixel {R,G,B}.
- avalon_streaming_source_valid, out, 1: pixel valid.
- avalon_streaming_source_ready, in, 1: sink ready; readyLatency 0.
- avalon_streaming_source_startofpacket, out, 1: first pixel (0,0).
- avalon_streaming_source_endofpacket, out, 1: last pixel (H_RES−1, V_RES−1).

## Operation
- Counters x (column) and y (row) track the next pixel to load. They wrap at H_RES and V_RES.
- A pixel is in-window when WIN_X0 ≤ x ≤ WIN_X1 and WIN_Y0 ≤ y ≤ WIN_Y1.
- In-window pixels take `data`, with each channel widened per EXPAND. Out-of-window pixels take BG.
- `address` always presents the line-buffer address of pixel (x,y): x−WIN_X0 when in-window, else 0.
- States:
  - IDLE: valid=0. `start`=1 moves to PRIME; x=y=0 and address=addr(0,0).
  - PRIME: one cycle while the RAM latency elapses; always moves to STREAM.
  - STREAM: advance = !valid || ready.
- On advance, the output register loads pixel (x,y) with sop=(x==0&&y==0) and eop=(x==H_RES−1&&y==V_RES−1). Valid is set. x and y step, and `address` updates to the next pixel's address.
- On stall (valid && !ready): data, sop, eop, valid, x, y and address all hold. The held address keeps `data` stable.
- End of frame: the eop pixel has been loaded and the counters have wrapped to (0,0).
  - If `start`=1 at that advance, streaming continues seamlessly; address(0,0) is already presented.
  - If `start`=0, no further loads occur. After the eop beat is accepted, valid drops and the state returns to IDLE.
  - `start` is ignored mid-frame.
- `next_row` pulses for the one cycle after the pixel with x==H_RES−ROW_LEAD is loaded, on every row.
- `next_screen` pulses for the one cycle after the pixel with y==V_RES−1 and x==H_RES−FRAME_LEAD is loaded.
- Reset (including mid-frame): state IDLE, x=y=0; valid, sop, eop, next_row and next_screen all 0; data=0; address=0. Any partial frame is abandoned, with no eop.

## Timing
- Start-up: `start` sampled high in IDLE at edge E0 → PRIME. E1 → STREAM. E2 loads pixel (0,0). Valid and sop are high from E2 onward.
- Steady state with ready=1: one pixel per clock. A frame is exactly H_RES*V_RES beats with no bubbles, including back-to-back frames.
- Stalls add no extra latency: the held beat transfers in the first cycle ready=1.
- Beat (x,y) is taken at the edge where valid && ready. The next beat appears on the following cycle.
- Widening, EXPAND=1 with IN=8, OUT=10: out = {in, in[7:6]}.

## Test plan
- Defaults, start=1, ready=1: valid rises 3 clocks after start. 307200 beats per frame; sop on beat 0, eop on beat 307199. Beat (80,0) carries data fetched at address 0; beat (79,0) = BG.
- H_RES=16, V_RES=4, window 4..11 × 1..2, RAM model data=address: row 0 all BG. Row 1 columns 4..11 carry 0..7; columns 0..3 and 12..15 are BG.
- Random ready (≈50%): the received pixel sequence is identical to the ready=1 run. Address and data are frozen during every stall.
- Drop start mid-frame: the frame completes with eop. Valid goes low the cycle after eop is accepted; no sop follows. Raising start restarts at (0,0).
- Small config, ROW_LEAD=3, FRAME_LEAD=5: next_row is a single-cycle pulse with beat (13,y) every row. next_screen pulses once, with beat (11,3).
- Assert reset_n=0 mid-row, at pixel (7,2), during a stall: all outputs are 0 immediately. After release, with start=1, the next frame starts with sop at (0,0).
